// File: rtl/i2c_csr_pkg.sv
// Shared types and constants for the I2C-to-CSR bridge.
package i2c_csr_pkg;

   typedef enum logic [3:0] {
      IDLE,
      DEVADDR,
      ACK_ADDR,
      REGADDR,
      ACK_REG,
      WRDATA,
      ACK_WR,
      RDDATA,
      RDACK,
      WAITSTOP
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam int   BCNT_W   = 3;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronises SCL/SDA into clk and derives single-cycle edge, START and STOP pulses.
module i2c_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);

   // [0],[1] are the synchroniser, [2] is the history flop; idle bus level is high
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl};
         sda_q <= {sda_q[1:0], sda_in};
      end
   end

   assign sda_s     = sda_q[1];
   assign scl_rise  = scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] & scl_q[2];
   assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_csr_bridge.sv
// I2C target that turns bus transactions into CSR writes and reads with an auto-incrementing pointer.
module i2c_csr_bridge
   import i2c_csr_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h4a,
   parameter int         CSR_AW   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic [CSR_AW-1:0] csr_a,
   output logic [7:0]        csr_di,
   output logic              csr_we,
   input  logic [7:0]        csr_do,
   output logic              busy
);

   logic scl_rise, scl_fall, sda_s, start_det, stop_det;

   i2c_sync_edge u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .sda_s     (sda_s),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   state_e              state_q, state_d;
   logic [BCNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]          sh_q, sh_d;
   logic [CSR_AW-1:0]   ptr_q, ptr_d;
   logic                rw_q, rw_d;
   logic                oe_q, oe_d;
   logic [CSR_AW-1:0]   csr_a_q, csr_a_d;
   logic [7:0]          csr_di_q, csr_di_d;
   logic                csr_we_q, csr_we_d;
   logic [1:0]          ld_q, ld_d;
   logic [7:0]          byte_in;
   logic                last_bit;

   assign byte_in  = {sh_q[6:0], sda_s};
   assign last_bit = (cnt_q == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         ptr_q    <= '0;
         rw_q     <= RW_WRITE;
         oe_q     <= 1'b0;
         csr_a_q  <= '0;
         csr_di_q <= '0;
         csr_we_q <= 1'b0;
         ld_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         ptr_q    <= ptr_d;
         rw_q     <= rw_d;
         oe_q     <= oe_d;
         csr_a_q  <= csr_a_d;
         csr_di_q <= csr_di_d;
         csr_we_q <= csr_we_d;
         ld_q     <= ld_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      ptr_d    = ptr_q;
      rw_d     = rw_q;
      oe_d     = oe_q;
      csr_a_d  = csr_a_q;
      csr_di_d = csr_di_q;
      csr_we_d = 1'b0;
      ld_d     = {ld_q[0], 1'b0};
      // read data is captured two clocks after csr_a was updated
      if (ld_q[1]) sh_d = csr_do;
      if (csr_we_q) ptr_d = ptr_q + 1'b1;

      if (start_det) begin
         state_d = DEVADDR;
         cnt_d   = '0;
         oe_d    = 1'b0;
      end else if (stop_det) begin
         state_d = IDLE;
         cnt_d   = '0;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            DEVADDR: if (scl_rise) begin
               sh_d  = byte_in;
               cnt_d = cnt_q + 1'b1;
               if (last_bit) begin
                  if (byte_in[7:1] == I2C_ADDR) begin
                     state_d = ACK_ADDR;
                     rw_d    = byte_in[0];
                  end else begin
                     state_d = WAITSTOP;
                  end
               end
            end
            ACK_ADDR: begin
               if (scl_rise && rw_q == RW_READ) begin
                  csr_a_d = ptr_q;
                  ld_d    = {ld_q[0], 1'b1};
               end
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d = 1'b1;
                  end else if (rw_q == RW_WRITE) begin
                     state_d = REGADDR;
                     cnt_d   = '0;
                     oe_d    = 1'b0;
                  end else begin
                     state_d = RDDATA;
                     cnt_d   = '0;
                     oe_d    = ~sh_q[7];
                  end
               end
            end
            REGADDR: if (scl_rise) begin
               sh_d  = byte_in;
               cnt_d = cnt_q + 1'b1;
               if (last_bit) begin
                  ptr_d   = byte_in[CSR_AW-1:0];
                  state_d = ACK_REG;
               end
            end
            ACK_REG, ACK_WR: if (scl_fall) begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else begin
                  state_d = WRDATA;
                  cnt_d   = '0;
                  oe_d    = 1'b0;
               end
            end
            WRDATA: if (scl_rise) begin
               sh_d  = byte_in;
               cnt_d = cnt_q + 1'b1;
               if (last_bit) begin
                  csr_a_d  = ptr_q;
                  csr_di_d = byte_in;
                  csr_we_d = 1'b1;
                  state_d  = ACK_WR;
               end
            end
            RDDATA: begin
               // bit 7 goes out on the falling edge that enters this state
               if (scl_fall) begin
                  if (cnt_q == '0) begin
                     oe_d = ~sh_q[7];
                  end else begin
                     sh_d = {sh_q[6:0], 1'b0};
                     oe_d = ~sh_q[6];
                  end
               end
               if (scl_rise) begin
                  cnt_d = cnt_q + 1'b1;
                  if (last_bit) begin
                     state_d = RDACK;
                     ptr_d   = ptr_q + 1'b1;
                  end
               end
            end
            RDACK: begin
               if (scl_fall) oe_d = 1'b0;
               if (scl_rise) begin
                  if (!sda_s) begin
                     state_d = RDDATA;
                     cnt_d   = '0;
                     csr_a_d = ptr_q;
                     ld_d    = {ld_q[0], 1'b1};
                  end else begin
                     state_d = WAITSTOP;
                     oe_d    = 1'b0;
                  end
               end
            end
            default: oe_d = 1'b0;
         endcase
      end
   end

   assign sda_oe = oe_q;
   assign csr_a  = csr_a_q;
   assign csr_di = csr_di_q;
   assign csr_we = csr_we_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_csr_bridge.sv
// Directed bench: an I2C master model drives the bridge against a small CSR memory model.
module tb_i2c_csr_bridge;

   localparam int Q = 5;  // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic [4:0] csr_a;
   logic [7:0] csr_di;
   logic       csr_we;
   logic [7:0] csr_do = 8'h00;
   logic       busy;

   logic [7:0]  mem [32];
   logic [12:0] exp_q[$];
   logic [12:0] got_q[$];
   int          chk_cnt = 0;
   int          err_cnt = 0;
   int          oe_cnt = 0;
   int          we_long = 0;
   logic        we_prev = 1'b0;

   assign sda_bus = m_sda & ~sda_oe;

   i2c_csr_bridge #(.I2C_ADDR(7'h4a), .CSR_AW(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .scl    (scl),
      .sda_in (sda_bus),
      .sda_oe (sda_oe),
      .csr_a  (csr_a),
      .csr_di (csr_di),
      .csr_we (csr_we),
      .csr_do (csr_do),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) csr_do <= mem[csr_a];

   always @(negedge clk) begin
      if (csr_we) begin
         got_q.push_back({csr_a, csr_di});
         if (we_prev) we_long++;
      end
      we_prev = csr_we;
      if (sda_oe) oe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_writes(input string tag);
      logic [12:0] e, g;
      check({tag, "_wr_count"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         check({tag, "_wr"}, g, e);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic wait_q(input int n);
      repeat (n * Q) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;
      wait_q(1);
      scl = 1'b1;
      wait_q(2);
      scl = 1'b0;
      wait_q(1);
   endtask

   task automatic start_c();
      m_sda = 1'b1;
      wait_q(1);
      scl = 1'b1;
      wait_q(1);
      m_sda = 1'b0;
      wait_q(1);
      scl = 1'b0;
      wait_q(1);
   endtask

   task automatic stop_c();
      m_sda = 1'b0;
      wait_q(1);
      scl = 1'b1;
      wait_q(1);
      m_sda = 1'b1;
      wait_q(2);
   endtask

   task automatic wb(input string tag, input logic [7:0] b, input logic exp_ack);
      logic ack;
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      m_sda = 1'b1;
      wait_q(1);
      scl = 1'b1;
      wait_q(1);
      ack = sda_bus;
      wait_q(1);
      scl = 1'b0;
      wait_q(1);
      check(tag, ack, exp_ack);
   endtask

   task automatic rb(input string tag, input logic master_ack, input logic [7:0] exp_d);
      logic [7:0] d;
      d = 8'h00;
      m_sda = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         wait_q(1);
         scl = 1'b1;
         wait_q(1);
         d[i] = sda_bus;
         wait_q(1);
         scl = 1'b0;
         wait_q(1);
      end
      m_sda = master_ack ? 1'b0 : 1'b1;
      wait_q(1);
      scl = 1'b1;
      wait_q(2);
      scl = 1'b0;
      m_sda = 1'b1;
      wait_q(1);
      check(tag, d, exp_d);
   endtask

   initial begin
      int oe_base;
      for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'hc3;
      mem[4] = 8'h10;
      mem[5] = 8'h5a;
      mem[6] = 8'h66;

      // reset state
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_csr_we", csr_we, 1'b0);
      check("rst_csr_a", csr_a, 5'h00);
      check("rst_csr_di", csr_di, 8'h00);
      check("rst_busy", busy, 1'b0);
      wait_q(2);

      // single write
      start_c();
      wb("wr_ack_dev", 8'h94, 1'b0);
      wb("wr_ack_reg", 8'h01, 1'b0);
      wb("wr_ack_dat", 8'haa, 1'b0);
      check("wr_busy_hi", busy, 1'b1);
      stop_c();
      check("wr_busy_lo", busy, 1'b0);
      exp_q.push_back({5'h01, 8'haa});
      check_writes("wr");

      // burst write with pointer wrap
      start_c();
      wb("bw_ack_dev", 8'h94, 1'b0);
      wb("bw_ack_reg", 8'h1f, 1'b0);
      wb("bw_ack_d0", 8'h11, 1'b0);
      wb("bw_ack_d1", 8'h22, 1'b0);
      stop_c();
      exp_q.push_back({5'h1f, 8'h11});
      exp_q.push_back({5'h00, 8'h22});
      check_writes("bw");

      // read with repeated START
      start_c();
      wb("rd_ack_dev", 8'h94, 1'b0);
      wb("rd_ack_reg", 8'h04, 1'b0);
      start_c();
      wb("rd_ack_devr", 8'h95, 1'b0);
      rb("rd_byte4", 1'b1, 8'h10);
      rb("rd_byte5", 1'b0, 8'h5a);
      stop_c();
      check("rd_busy_lo", busy, 1'b0);
      check_writes("rd");
      // current-address read shows where the pointer ended
      start_c();
      wb("rd6_ack_dev", 8'h95, 1'b0);
      rb("rd6_byte", 1'b0, 8'h66);
      stop_c();
      check("rd6_csr_a", csr_a, 5'h06);
      check_writes("rd6");

      // wrong device address
      oe_base = oe_cnt;
      start_c();
      wb("na_ack_dev", 8'h96, 1'b1);
      wb("na_ack_reg", 8'h01, 1'b1);
      wb("na_ack_dat", 8'hff, 1'b1);
      check("na_busy_hi", busy, 1'b1);
      stop_c();
      check("na_busy_lo", busy, 1'b0);
      check("na_oe_cycles", oe_cnt - oe_base, 0);
      check_writes("na");

      // reset during the 4th data bit
      start_c();
      wb("rs_ack_dev", 8'h94, 1'b0);
      wb("rs_ack_reg", 8'h02, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      m_sda = 1'b1;
      wait_q(1);
      rst = 1'b1;
      @(negedge clk);
      check("rs_sda_oe", sda_oe, 1'b0);
      check("rs_csr_we", csr_we, 1'b0);
      check("rs_busy", busy, 1'b0);
      rst = 1'b0;
      wait_q(1);
      scl = 1'b1;
      wait_q(2);
      check_writes("rs_abort");
      start_c();
      wb("rs2_ack_dev", 8'h94, 1'b0);
      wb("rs2_ack_reg", 8'h02, 1'b0);
      wb("rs2_ack_dat", 8'h33, 1'b0);
      stop_c();
      exp_q.push_back({5'h02, 8'h33});
      check_writes("rs2");

      // START in the middle of a byte
      start_c();
      wb("sm_ack_dev", 8'h94, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      start_c();
      wb("sm2_ack_dev", 8'h94, 1'b0);
      wb("sm2_ack_reg", 8'h03, 1'b0);
      wb("sm2_ack_dat", 8'h0f, 1'b0);
      stop_c();
      exp_q.push_back({5'h03, 8'h0f});
      check_writes("sm");

      check("we_pulse_width", we_long, 0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
